// File: rtl/apb_slave_regs.sv
// APB slave with six RW registers, a read-only ID and a transfer counter.
// Optional wait states are enabled by defining APB_SLV_WAIT_EN.
module apb_slave_regs #(
   parameter int unsigned ADDR_WIDTH  = 32,
   parameter int unsigned WAIT_CYCLES = 2,
   parameter logic [31:0] ID_VALUE    = 32'hA9B0_0001
) (
   input  logic                  hclk,
   input  logic                  hreset,
   input  logic                  psel,
   input  logic                  penable,
   input  logic [ADDR_WIDTH-1:0] paddr,
   input  logic                  pwrite,
   input  logic [31:0]           pwdata,
   output logic [31:0]           prdata,
   output logic                  pready,
   output logic                  pslverr
);

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_WAIT = 2'd1;
   localparam logic [1:0] ST_RESP = 2'd2;

   localparam logic [3:0] WAIT_LOAD = 4'(WAIT_CYCLES);
`ifdef APB_SLV_WAIT_EN
   localparam bit WAIT_EN = (WAIT_CYCLES != 0);
`else
   localparam bit WAIT_EN = 1'b0;
`endif

   logic [1:0]  state, state_nxt;
   logic [3:0]  wait_cnt, cnt_nxt;
   logic [31:0] regs [6];
   logic [31:0] xfer_cnt;
   logic [11:0] offset;
   logic        acc_err;
   logic        enter_resp;
   logic        wr_commit;
   logic [31:0] rd_data;

   generate
      if (ADDR_WIDTH > 12) begin : g_hi_addr
         logic unused_addr;
         assign unused_addr = ^paddr[ADDR_WIDTH-1:12];
      end
   endgenerate

   assign offset  = paddr[11:0];
   assign acc_err = (offset >= 12'h020) || (offset[1:0] != 2'b00) ||
                    (pwrite && (offset[4:2] >= 3'd6));

   always_comb begin
      rd_data = '0;
      case (offset[4:2])
         3'd0:    rd_data = regs[0];
         3'd1:    rd_data = regs[1];
         3'd2:    rd_data = regs[2];
         3'd3:    rd_data = regs[3];
         3'd4:    rd_data = regs[4];
         3'd5:    rd_data = regs[5];
         3'd6:    rd_data = ID_VALUE;
         default: rd_data = xfer_cnt;
      endcase
   end

   always_comb begin
      state_nxt = state;
      cnt_nxt   = wait_cnt;
      case (state)
         ST_IDLE: begin
            if (psel && !penable) begin
               cnt_nxt   = WAIT_LOAD;
               state_nxt = WAIT_EN ? ST_WAIT : ST_RESP;
            end
         end
         ST_WAIT: begin
            // Any drop of the handshake during wait states abandons the transfer.
            if (!(psel && penable)) begin
               state_nxt = ST_IDLE;
            end else begin
               cnt_nxt = wait_cnt - 4'd1;
               if (wait_cnt <= 4'd1) state_nxt = ST_RESP;
            end
         end
         ST_RESP: state_nxt = ST_IDLE;
         default: state_nxt = ST_IDLE;
      endcase
   end

   assign enter_resp = (state != ST_RESP) && (state_nxt == ST_RESP);
   assign wr_commit  = (state == ST_RESP) && psel && penable && pready &&
                       pwrite && !pslverr;

   always_ff @(posedge hclk) begin
      if (hreset) begin
         state    <= ST_IDLE;
         wait_cnt <= '0;
         pready   <= 1'b0;
         pslverr  <= 1'b0;
         prdata   <= '0;
         xfer_cnt <= '0;
         for (int unsigned i = 0; i < 6; i++) regs[i] <= '0;
      end else begin
         state    <= state_nxt;
         wait_cnt <= cnt_nxt;
         pready   <= enter_resp;
         pslverr  <= enter_resp && acc_err;
         prdata   <= (enter_resp && !acc_err && !pwrite) ? rd_data : '0;
         if (state == ST_RESP) xfer_cnt <= xfer_cnt + 32'd1;
         for (int unsigned i = 0; i < 6; i++) begin
            if (wr_commit && (offset[4:2] == 3'(i))) regs[i] <= pwdata;
         end
      end
   end

endmodule
